// File: rtl/arb16_pkg.sv
// Shared definitions for the 16-way round-robin arbiter:
// the state encoding and the fixed requester/index sizes.
package arb16_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        GAP  = 2'b10
    } arb_state_t;

endpackage

// File: rtl/decoder_4_to_16_bh.sv
// Behavioural 4-to-16 decoder with enable.
// It turns the registered grant index into the one-hot grant bus.
module decoder_4_to_16_bh (
    input  logic [3:0]  A,
    input  logic        E,
    output logic [15:0] Y
);

    always_comb begin
        Y = '0;
        if (E) begin
            Y[A] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters with bounded hold time.
// Each handover inserts one dead cycle, so two grants are never active together.
module rr_arbiter16
    import arb16_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);

    localparam int HC_W = $clog2(MAX_HOLD);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [HC_W-1:0]  hold_cnt;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             others_req;

    // Scans from farthest to nearest so the candidate closest after p wins.
    function automatic logic [IDX_W:0] find_next(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = p + IDX_W'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        {pick_found, pick_idx} = find_next(req, ptr);
        others_req = |(req & ~(N_REQ'(1) << gnt_idx));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_idx   <= '0;
            ptr       <= '1;
            hold_cnt  <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (pick_found) begin
                        state     <= BUSY;
                        gnt_idx   <= pick_idx;
                        hold_cnt  <= '0;
                        gnt_valid <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        gnt_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    // A release wins over expiry, so it never raises preempt.
                    if (!req[gnt_idx]) begin
                        state     <= GAP;
                        ptr       <= gnt_idx;
                        gnt_valid <= 1'b0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        if (others_req) begin
                            state     <= GAP;
                            ptr       <= gnt_idx;
                            gnt_valid <= 1'b0;
                            preempt   <= 1'b1;
                        end else begin
                            hold_cnt <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    decoder_4_to_16_bh u_dec (
        .A (gnt_idx),
        .E (gnt_valid),
        .Y (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16: directed scenarios plus random traffic,
// each cycle compared against a cycle-level model of the arbitration rules.
module tb_rr_arbiter16;

    localparam int MAX_HOLD = 8;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        preempt;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the resource and for how many cycles it has served.
    bit          m_granted;
    int          m_owner;
    int          m_ptr;
    int          m_served;
    bit          m_pre;
    logic [15:0] prev_gnt;

    rr_arbiter16 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelStep(input logic [15:0] r, input logic rn);
        bit others;
        int cand;
        if (!rn) begin
            m_granted = 0;
            m_owner   = 0;
            m_ptr     = 15;
            m_served  = 0;
            m_pre     = 0;
        end else if (m_granted) begin
            others = (r & ~(16'h0001 << m_owner)) != 16'h0000;
            if (!r[m_owner]) begin
                m_granted = 0;
                m_ptr     = m_owner;
                m_pre     = 0;
            end else if (m_served == MAX_HOLD) begin
                if (others) begin
                    m_granted = 0;
                    m_ptr     = m_owner;
                    m_pre     = 1;
                end else begin
                    m_served = 1;
                    m_pre    = 0;
                end
            end else begin
                m_served++;
                m_pre = 0;
            end
        end else begin
            m_pre = 0;
            if (r != 16'h0000) begin
                for (int k = 1; k <= 16; k++) begin
                    cand = (m_ptr + k) % 16;
                    if (r[cand]) begin
                        m_owner = cand;
                        break;
                    end
                end
                m_granted = 1;
                m_served  = 1;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [15:0] exp_gnt;
        exp_gnt = m_granted ? (16'h0001 << m_owner) : 16'h0000;
        total++;
        assert (gnt === exp_gnt) else begin
            bad++;
            $error("[TB] FAIL %s gnt: observed=%h expected=%h", tag, gnt, exp_gnt);
        end
        total++;
        assert (gnt_valid === m_granted) else begin
            bad++;
            $error("[TB] FAIL %s gnt_valid: observed=%b expected=%b", tag, gnt_valid, m_granted);
        end
        total++;
        assert (preempt === m_pre) else begin
            bad++;
            $error("[TB] FAIL %s preempt: observed=%b expected=%b", tag, preempt, m_pre);
        end
        total++;
        assert (gnt_idx === 4'(m_owner)) else begin
            bad++;
            $error("[TB] FAIL %s gnt_idx: observed=%0d expected=%0d", tag, gnt_idx, m_owner);
        end
        total++;
        assert ($countones(gnt) <= 1) else begin
            bad++;
            $error("[TB] FAIL %s onehot: observed=%h expected at most one bit", tag, gnt);
        end
        // A change of owner must pass through an all-zero cycle.
        if (prev_gnt != 16'h0000 && gnt != 16'h0000) begin
            total++;
            assert (gnt === prev_gnt) else begin
                bad++;
                $error("[TB] FAIL %s handover: observed=%h expected=%h", tag, gnt, prev_gnt);
            end
        end
        prev_gnt = gnt;
    endtask

    task automatic applyStimulus(input logic [15:0] r, input logic rn, input string tag);
        req   = r;
        rst_n = rn;
        @(posedge clk);
        modelStep(r, rn);
        #1;
        checkOutput(tag);
    endtask

    task automatic expectGnt(input string tag, input logic [15:0] exp);
        total++;
        assert (gnt === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, gnt, exp);
        end
    endtask

    task automatic expectCount(input string tag, input int observed, input int expected);
        total++;
        assert (observed == expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        logic [15:0] wrap_req [7];
        logic [15:0] wrap_gnt [7];
        logic [15:0] pat;
        logic [15:0] r;
        logic        rn;
        int          pre_seen;
        int          held_seen;
        int          len;

        prev_gnt = 16'h0000;
        m_granted = 0; m_owner = 0; m_ptr = 15; m_served = 0; m_pre = 0;

        $display("[TB] reset");
        applyStimulus(16'hFFFF, 1'b0, "reset0");
        applyStimulus(16'hFFFF, 1'b0, "reset1");
        expectGnt("reset_gnt", 16'h0000);
        applyStimulus(16'hFFFF, 1'b1, "reset_rel");
        expectGnt("first_grant", 16'h0001);
        applyStimulus(16'h0000, 1'b1, "drain");
        applyStimulus(16'h0000, 1'b1, "drain");

        $display("[TB] single requester");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'h0020, 1'b1, "single");
            expectGnt("single_gnt", 16'h0020);
        end
        applyStimulus(16'h0000, 1'b1, "single_gap");
        expectGnt("single_gap_gnt", 16'h0000);
        applyStimulus(16'h0000, 1'b1, "single_idle");

        $display("[TB] wrap-around");
        applyStimulus(16'h0000, 1'b0, "wrap_reset");
        wrap_req = '{16'h8001, 16'h8001, 16'h8000, 16'h8001, 16'h8001, 16'h0001, 16'h8001};
        wrap_gnt = '{16'h0001, 16'h0001, 16'h0000, 16'h8000, 16'h8000, 16'h0000, 16'h0001};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(wrap_req[i], 1'b1, "wrap");
            expectGnt("wrap_seq", wrap_gnt[i]);
        end
        applyStimulus(16'h0000, 1'b1, "drain");
        applyStimulus(16'h0000, 1'b1, "drain");

        $display("[TB] preemption");
        pre_seen = 0;
        for (int i = 0; i < 19; i++) begin
            applyStimulus(16'h0006, 1'b1, "preempt");
            if (preempt === 1'b1) pre_seen++;
        end
        expectCount("preempt_pulses", pre_seen, 2);
        expectGnt("preempt_back_to_idx1", 16'h0002);
        applyStimulus(16'h0000, 1'b1, "drain");
        applyStimulus(16'h0000, 1'b1, "drain");

        $display("[TB] uncontended expiry");
        pre_seen  = 0;
        held_seen = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(16'h0010, 1'b1, "uncontended");
            if (preempt === 1'b1) pre_seen++;
            if (gnt === 16'h0010) held_seen++;
        end
        expectCount("uncontended_preempt", pre_seen, 0);
        expectCount("uncontended_held", held_seen, 20);
        applyStimulus(16'h0000, 1'b1, "drain");
        applyStimulus(16'h0000, 1'b1, "drain");

        $display("[TB] reset mid-grant");
        applyStimulus(16'h0020, 1'b1, "midreset_busy");
        applyStimulus(16'h0020, 1'b1, "midreset_busy");
        expectGnt("midreset_busy_gnt", 16'h0020);
        applyStimulus(16'h0020, 1'b0, "midreset");
        expectGnt("midreset_gnt", 16'h0000);
        applyStimulus(16'h0021, 1'b1, "midreset_first");
        expectGnt("midreset_idx0", 16'h0001);
        applyStimulus(16'h0020, 1'b1, "midreset_gap");
        expectGnt("midreset_gap_gnt", 16'h0000);
        applyStimulus(16'h0020, 1'b1, "midreset_next");
        expectGnt("midreset_idx5", 16'h0020);

        $display("[TB] random traffic");
        for (int s = 0; s < 60; s++) begin
            pat = 16'($urandom & $urandom);
            if ($urandom_range(0, 3) == 0) pat = 16'h0001 << $urandom_range(0, 15);
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                r = pat;
                if ($urandom_range(0, 7) == 0) r = r ^ (16'h0001 << $urandom_range(0, 15));
                rn = ($urandom_range(0, 99) != 0);
                applyStimulus(r, rn, "random");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
